// File: rtl/apb_regs_slave.sv
// APB4 register-file completer: NumRegs word registers at BaseAddr with
// programmable wait states, error signalling and hardware export ports.

package apb_regs_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_rsp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

endpackage

// Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by
// access cycles (psel=1, penable=1). The transfer completes in the access
// cycle where pready=1; prdata and pslverr are only meaningful in that cycle
// and are driven to 0 otherwise. Dropping psel abandons the transfer.
module apb_regs_slave #(
    parameter int unsigned                    NumRegs      = 16,
    parameter int unsigned                    AddrWidth    = 32,
    parameter int unsigned                    DataWidth    = 32,
    parameter logic [AddrWidth-1:0]           BaseAddr     = 32'h0000_3000,
    parameter logic [NumRegs-1:0]             ReadOnlyMask = '0,
    parameter logic [NumRegs*DataWidth-1:0]   RegRstVal    = '0,
    parameter int unsigned                    WaitCycles   = 0,
    parameter type                            apb_req_t    = apb_regs_pkg::apb_req_t,
    parameter type                            apb_rsp_t    = apb_regs_pkg::apb_rsp_t
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  apb_req_t                            apb_req_i,
    output apb_rsp_t                            apb_rsp_o,
    output logic [NumRegs-1:0][DataWidth-1:0]   reg_q_o,
    input  logic [NumRegs-1:0][DataWidth-1:0]   reg_d_i,
    output logic [NumRegs-1:0]                  reg_wr_o,
    output apb_regs_pkg::state_e                dbg_state_o
);

    localparam int unsigned           Bytes     = DataWidth / 8;
    localparam int unsigned           AddrLsb   = (Bytes > 1) ? $clog2(Bytes) : 0;
    localparam logic [AddrWidth-1:0]  AlignMask = AddrWidth'(Bytes - 1);
    localparam logic [AddrWidth:0]    BaseExt   = {1'b0, BaseAddr};
    localparam logic [AddrWidth:0]    EndExt    = BaseExt + (AddrWidth+1)'(NumRegs * Bytes);
    localparam logic [3:0]            WaitLimit = 4'(WaitCycles);

    apb_regs_pkg::state_e state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;

    logic [AddrWidth-1:0] paddr;
    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] word;
    logic [DataWidth-1:0] pwdata;
    logic [Bytes-1:0]     pstrb;
    logic                 psel, penable, pwrite;
    logic                 hit, aligned, ro_hit, err;
    logic                 in_access, pready, wr_en;
    logic [NumRegs-1:0]   sel;
    logic [DataWidth-1:0] rd_word;
    logic                 unused_pprot;

    assign paddr        = apb_req_i.paddr;
    assign pwdata       = apb_req_i.pwdata;
    assign pstrb        = apb_req_i.pstrb;
    assign psel         = apb_req_i.psel;
    assign penable      = apb_req_i.penable;
    assign pwrite       = apb_req_i.pwrite;
    assign unused_pprot = ^apb_req_i.pprot;

    // Address decode: widened compare so the window end cannot wrap.
    assign off     = paddr - BaseAddr;
    assign word    = off >> AddrLsb;
    assign hit     = ({1'b0, paddr} >= BaseExt) && ({1'b0, paddr} < EndExt);
    assign aligned = (paddr & AlignMask) == '0;
    assign ro_hit  = |(sel & ReadOnlyMask);
    assign err     = !hit || !aligned || (pwrite && ro_hit);

    // One-hot register select and read data mux.
    always_comb begin
        sel     = '0;
        rd_word = '0;
        for (int i = 0; i < NumRegs; i++) begin
            sel[i] = hit && (word == AddrWidth'(i));
            if (sel[i]) rd_word = reg_q_o[i];
        end
    end

    // The access phase only exists once the FSM has seen the setup cycle;
    // reset kills any completion in the same cycle.
    assign in_access = (state_q != apb_regs_pkg::IDLE) && psel && penable;
    assign pready    = !rst_i && in_access && (cnt_q == WaitLimit);
    assign wr_en     = pready && pwrite && !err;

    // Response drive: data and error are zero unless the transfer completes.
    always_comb begin
        apb_rsp_o         = '0;
        apb_rsp_o.pready  = pready;
        apb_rsp_o.pslverr = pready && err;
        apb_rsp_o.prdata  = (pready && !err && !pwrite) ? rd_word : '0;
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= apb_regs_pkg::IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: SETUP marks the first access cycle, ACCESS counts waits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            apb_regs_pkg::IDLE: begin
                cnt_d = '0;
                if (psel && !penable) state_d = apb_regs_pkg::SETUP;
            end
            apb_regs_pkg::SETUP, apb_regs_pkg::ACCESS: begin
                if (!psel) begin
                    state_d = apb_regs_pkg::IDLE;
                    cnt_d   = '0;
                end else if (!penable) begin
                    state_d = apb_regs_pkg::SETUP;
                    cnt_d   = '0;
                end else if (pready) begin
                    state_d = apb_regs_pkg::IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = apb_regs_pkg::ACCESS;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = apb_regs_pkg::IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dbg_state_o = state_q;

    // Register storage: read-only slots pass the hardware value straight through.
    for (genvar i = 0; i < NumRegs; i++) begin : g_reg
        if (ReadOnlyMask[i]) begin : g_ro
            assign reg_q_o[i] = reg_d_i[i];
        end else begin : g_rw
            logic [DataWidth-1:0] q;
            logic                 unused_d;

            assign unused_d = ^reg_d_i[i];

            // Byte-masked write on a committed transfer to this slot.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q <= RegRstVal[i*DataWidth +: DataWidth];
                end else if (wr_en && sel[i]) begin
                    for (int b = 0; b < Bytes; b++) begin
                        if (pstrb[b]) q[b*8 +: 8] <= pwdata[b*8 +: 8];
                    end
                end
            end

            assign reg_q_o[i] = q;
        end
    end

    // Write pulse: one cycle, aligned with the new register value.
    always_ff @(posedge clk_i) begin
        if (rst_i) reg_wr_o <= '0;
        else       reg_wr_o <= wr_en ? sel : '0;
    end

endmodule

// File: tb/tb_apb_regs_slave.sv
// Directed bench for apb_regs_slave: two instances, one with no wait states
// and read-only slots 0/1, one with three wait states and all slots writable.

module tb_apb_regs_slave;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    apb_regs_pkg::apb_req_t req0, req1;
    apb_regs_pkg::apb_rsp_t rsp0, rsp1;
    logic [15:0][31:0]      reg_q0, reg_q1, reg_d;
    logic [15:0]            reg_wr0, reg_wr1;
    apb_regs_pkg::state_e   st0, st1;

    function automatic logic [511:0] mk_rst_vals();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'hA500_0000 + i;
        return v;
    endfunction

    localparam logic [511:0] RstVals = mk_rst_vals();

    apb_regs_slave #(
        .NumRegs(16), .AddrWidth(32), .DataWidth(32), .BaseAddr(32'h0000_3000),
        .ReadOnlyMask(16'h0003), .RegRstVal(RstVals), .WaitCycles(0)
    ) u_ws0 (
        .clk_i(clk), .rst_i(rst), .apb_req_i(req0), .apb_rsp_o(rsp0),
        .reg_q_o(reg_q0), .reg_d_i(reg_d), .reg_wr_o(reg_wr0), .dbg_state_o(st0)
    );

    apb_regs_slave #(
        .NumRegs(16), .AddrWidth(32), .DataWidth(32), .BaseAddr(32'h0000_3000),
        .ReadOnlyMask(16'h0000), .RegRstVal(RstVals), .WaitCycles(3)
    ) u_ws3 (
        .clk_i(clk), .rst_i(rst), .apb_req_i(req1), .apb_rsp_o(rsp1),
        .reg_q_o(reg_q1), .reg_d_i(reg_d), .reg_wr_o(reg_wr1), .dbg_state_o(st1)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int lane, input apb_regs_pkg::apb_req_t r);
        if (lane == 0) req0 = r;
        else           req1 = r;
    endtask

    task automatic bus_idle(input int lane);
        drive(lane, '0);
    endtask

    // One full transfer starting with its setup cycle now; returns just after
    // the edge following completion, with the request still on the bus.
    task automatic apb_xfer(input int lane, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err, output int waits);
        apb_regs_pkg::apb_req_t r;
        apb_regs_pkg::apb_rsp_t s;
        bit done;
        r = '0;
        r.paddr = addr; r.psel = 1'b1; r.pwrite = wr; r.pwdata = wdata; r.pstrb = strb;
        drive(lane, r);
        tick();
        r.penable = 1'b1;
        drive(lane, r);
        waits = 0; done = 0; rdata = '0; err = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #3;
            s = (lane == 0) ? rsp0 : rsp1;
            if (s.pready) begin
                rdata = s.prdata; err = s.pslverr; done = 1;
            end else begin
                waits++;
            end
            tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL xfer_timeout lane%0d addr %h: no pready in 20 cycles, expected completion", lane, addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle(0); bus_idle(1);
        repeat (3) tick();
        rst = 1'b0;
        #3;
        checks++; if (rsp0.pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b expected 0", rsp0.pready); end
        checks++; if (rsp0.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h expected 0", rsp0.prdata); end
        checks++; if (rsp0.pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b expected 0", rsp0.pslverr); end
        checks++; if (reg_wr0 !== 16'h0) begin errors++; $display("FAIL reset_reg_wr0: got %h expected 0", reg_wr0); end
        checks++; if (reg_wr1 !== 16'h0) begin errors++; $display("FAIL reset_reg_wr1: got %h expected 0", reg_wr1); end
        checks++; if (st1 !== apb_regs_pkg::IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", st1); end
        checks++; if (reg_q0[5] !== 32'hA500_0005) begin errors++; $display("FAIL reset_q0_5: got %h expected a5000005", reg_q0[5]); end
        checks++; if (reg_q1[5] !== 32'hA500_0005) begin errors++; $display("FAIL reset_q1_5: got %h expected a5000005", reg_q1[5]); end
        checks++; if (reg_q0[0] !== 32'h0D00_0000) begin errors++; $display("FAIL reset_ro_q0_0: got %h expected 0d000000", reg_q0[0]); end
    endtask

    task automatic test_write_read_ws0();
        logic [31:0] rd; logic er; int w;
        apb_xfer(0, 32'h3008, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, w);
        checks++; if (w !== 0) begin errors++; $display("FAIL ws0_write_waits: got %0d expected 0", w); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ws0_write_err: got %b expected 0", er); end
        checks++; if (reg_q0[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws0_q2: got %h expected deadbeef", reg_q0[2]); end
        checks++; if (reg_wr0 !== 16'h0004) begin errors++; $display("FAIL ws0_wr_pulse: got %h expected 0004", reg_wr0); end
        // Back-to-back read of the register just written.
        apb_xfer(0, 32'h3008, 1'b0, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws0_read: got %h expected deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ws0_read_err: got %b expected 0", er); end
        checks++; if (w !== 0) begin errors++; $display("FAIL ws0_read_waits: got %0d expected 0", w); end
        checks++; if (reg_wr0 !== 16'h0) begin errors++; $display("FAIL ws0_read_no_pulse: got %h expected 0", reg_wr0); end
        bus_idle(0);
        tick();
    endtask

    task automatic test_partial_strobe_ws3();
        logic [31:0] rd; logic er; int w;
        apb_xfer(1, 32'h3008, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, w);
        checks++; if (w !== 3) begin errors++; $display("FAIL ws3_full_waits: got %0d expected 3", w); end
        apb_xfer(1, 32'h3008, 1'b1, 32'h1122_3344, 4'b0101, rd, er, w);
        checks++; if (w !== 3) begin errors++; $display("FAIL ws3_strb_waits: got %0d expected 3", w); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ws3_strb_err: got %b expected 0", er); end
        checks++; if (reg_q1[2] !== 32'hDE22_BE44) begin errors++; $display("FAIL ws3_strb_q2: got %h expected de22be44", reg_q1[2]); end
        checks++; if (reg_wr1 !== 16'h0004) begin errors++; $display("FAIL ws3_wr_pulse: got %h expected 0004", reg_wr1); end
        bus_idle(1);
        tick();
        checks++; if (reg_wr1 !== 16'h0) begin errors++; $display("FAIL ws3_pulse_width: got %h expected 0", reg_wr1); end
    endtask

    task automatic test_read_only();
        logic [31:0] rd; logic er; int w;
        reg_d[1] = 32'hCAFE_0001;
        apb_xfer(0, 32'h3004, 1'b1, 32'h1234_5678, 4'hF, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL ro_write_err: got %b expected 1", er); end
        checks++; if (reg_q0[1] !== 32'hCAFE_0001) begin errors++; $display("FAIL ro_q1: got %h expected cafe0001", reg_q0[1]); end
        checks++; if (reg_wr0 !== 16'h0) begin errors++; $display("FAIL ro_no_pulse: got %h expected 0", reg_wr0); end
        apb_xfer(0, 32'h3004, 1'b0, 32'h0, 4'h0, rd, er, w);
        checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL ro_read: got %h expected cafe0001", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL ro_read_err: got %b expected 0", er); end
        bus_idle(0);
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int w;
        apb_xfer(0, 32'h3040, 1'b0, 32'h0, 4'h0, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL miss_err: got %b expected 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL miss_rdata: got %h expected 0", rd); end
        apb_xfer(0, 32'h3006, 1'b0, 32'h0, 4'h0, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL unaligned_err: got %b expected 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unaligned_rdata: got %h expected 0", rd); end
        apb_xfer(0, 32'h3044, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, w);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL miss_write_err: got %b expected 1", er); end
        checks++; if (reg_wr0 !== 16'h0) begin errors++; $display("FAIL miss_write_pulse: got %h expected 0", reg_wr0); end
        bus_idle(0);
        tick();
    endtask

    task automatic test_psel_drop();
        apb_regs_pkg::apb_req_t r;
        r = '0;
        r.paddr = 32'h300C; r.psel = 1'b1; r.pwrite = 1'b1; r.pwdata = 32'h5555_5555; r.pstrb = 4'hF;
        drive(1, r);
        tick();
        r.penable = 1'b1;
        drive(1, r);
        #3;
        checks++; if (rsp1.pready !== 1'b0) begin errors++; $display("FAIL drop_wait_pready: got %b expected 0", rsp1.pready); end
        tick();
        tick();
        bus_idle(1);
        #3;
        checks++; if (rsp1.pready !== 1'b0) begin errors++; $display("FAIL drop_pready: got %b expected 0", rsp1.pready); end
        tick();
        checks++; if (st1 !== apb_regs_pkg::IDLE) begin errors++; $display("FAIL drop_state: got %0d expected 0", st1); end
        checks++; if (reg_q1[3] !== 32'hA500_0003) begin errors++; $display("FAIL drop_q3: got %h expected a5000003", reg_q1[3]); end
        checks++; if (reg_wr1 !== 16'h0) begin errors++; $display("FAIL drop_pulse: got %h expected 0", reg_wr1); end
        tick();
        checks++; if (reg_wr1 !== 16'h0) begin errors++; $display("FAIL drop_pulse_late: got %h expected 0", reg_wr1); end
    endtask

    task automatic test_reset_mid_write();
        apb_regs_pkg::apb_req_t r0, r1;
        logic [31:0] rd; logic er; int w;
        r1 = '0;
        r1.paddr = 32'h3010; r1.psel = 1'b1; r1.pwrite = 1'b1; r1.pwdata = 32'h7777_7777; r1.pstrb = 4'hF;
        drive(1, r1);
        tick();
        r1.penable = 1'b1;
        drive(1, r1);
        r0 = '0;
        r0.paddr = 32'h3014; r0.psel = 1'b1; r0.pwrite = 1'b1; r0.pwdata = 32'h9999_9999; r0.pstrb = 4'hF;
        drive(0, r0);
        tick();
        // Lane 1 is in its 2nd wait cycle; lane 0 would complete this cycle.
        r0.penable = 1'b1;
        drive(0, r0);
        rst = 1'b1;
        #3;
        checks++; if (rsp1.pready !== 1'b0) begin errors++; $display("FAIL rst_ws3_pready: got %b expected 0", rsp1.pready); end
        checks++; if (rsp0.pready !== 1'b0) begin errors++; $display("FAIL rst_ws0_pready: got %b expected 0", rsp0.pready); end
        tick();
        rst = 1'b0;
        bus_idle(0); bus_idle(1);
        #3;
        checks++; if (reg_q1[4] !== 32'hA500_0004) begin errors++; $display("FAIL rst_q1_4: got %h expected a5000004", reg_q1[4]); end
        checks++; if (reg_q0[5] !== 32'hA500_0005) begin errors++; $display("FAIL rst_q0_5: got %h expected a5000005", reg_q0[5]); end
        checks++; if (reg_wr0 !== 16'h0) begin errors++; $display("FAIL rst_wr0: got %h expected 0", reg_wr0); end
        checks++; if (st1 !== apb_regs_pkg::IDLE) begin errors++; $display("FAIL rst_state1: got %0d expected 0", st1); end
        checks++; if (st0 !== apb_regs_pkg::IDLE) begin errors++; $display("FAIL rst_state0: got %0d expected 0", st0); end
        tick();
        apb_xfer(1, 32'h3010, 1'b1, 32'h7777_7777, 4'hF, rd, er, w);
        checks++; if (w !== 3) begin errors++; $display("FAIL post_rst_waits: got %0d expected 3", w); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL post_rst_err: got %b expected 0", er); end
        checks++; if (reg_q1[4] !== 32'h7777_7777) begin errors++; $display("FAIL post_rst_q4: got %h expected 77777777", reg_q1[4]); end
        checks++; if (reg_wr1 !== 16'h0010) begin errors++; $display("FAIL post_rst_pulse: got %h expected 0010", reg_wr1); end
        bus_idle(1);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req0   = '0;
        req1   = '0;
        for (int i = 0; i < 16; i++) reg_d[i] = 32'h0D00_0000 + i;
        test_reset();
        test_write_read_ws0();
        test_partial_strobe_ws3();
        test_read_only();
        test_errors();
        test_psel_drop();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
